// File: rtl/bp_counter_table_if.sv
// Lookup/update bus between fetch, execute and the bp_counter_table predictor.
// The master drives requests; the slave (predictor) returns registered predictions.
interface bp_counter_table_if #(
    parameter int PC_WIDTH = 32,
    parameter int IDX_BITS = 6
);
    logic                lookup;
    logic [PC_WIDTH-1:0] lookup_pc;
    logic                prediction;
    logic                pred_valid;
    logic [IDX_BITS-1:0] pred_hist;
    logic                branch;
    logic [PC_WIDTH-1:0] upd_pc;
    logic                taken;
    logic [IDX_BITS-1:0] upd_hist;

    modport master (
        output lookup, lookup_pc, branch, upd_pc, taken, upd_hist,
        input  prediction, pred_valid, pred_hist
    );

    modport slave (
        input  lookup, lookup_pc, branch, upd_pc, taken, upd_hist,
        output prediction, pred_valid, pred_hist
    );
endinterface

// File: rtl/bp_counter_table.sv
// Table of 2^IDX_BITS saturating counters with a 1-cycle registered lookup and one update per cycle.
// Define BP_COUNTER_TABLE_GHR_EN for gshare indexing; otherwise the table is bimodal.
module bp_counter_table #(
    parameter int CNT_WIDTH = 2,
    parameter int IDX_BITS  = 6,
    parameter int PC_WIDTH  = 32
) (
    input logic               clk,
    input logic               reset,
    bp_counter_table_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

    logic [CNT_WIDTH-1:0] table_q [ENTRIES];
    logic [IDX_BITS-1:0]  lk_idx;
    logic [IDX_BITS-1:0]  upd_idx;
    logic [IDX_BITS-1:0]  lk_hist;
    logic [CNT_WIDTH-1:0] upd_cnt;
    logic [CNT_WIDTH-1:0] upd_cnt_d;
    logic                 prediction_q;
    logic                 pred_valid_q;
    logic [IDX_BITS-1:0]  pred_hist_q;
    logic                 unused_pc;

    // Only the word-index bits of the PCs select an entry.
    assign unused_pc = ^{bus.lookup_pc, bus.upd_pc};

`ifdef BP_COUNTER_TABLE_GHR_EN
    logic [IDX_BITS-1:0] ghr_q;
    logic [IDX_BITS-1:0] ghr_d;

    assign lk_idx  = bus.lookup_pc[IDX_BITS+1:2] ^ ghr_q;
    assign upd_idx = bus.upd_pc[IDX_BITS+1:2] ^ bus.upd_hist;
    assign lk_hist = ghr_q;
    assign ghr_d   = IDX_BITS'({ghr_q, bus.taken});

    // NOTE: non-blocking assignments keep the same-edge lookup on the pre-shift history.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else if (bus.branch) begin
            ghr_q <= ghr_d;
        end
    end
`else
    logic unused_hist;

    assign lk_idx      = bus.lookup_pc[IDX_BITS+1:2];
    assign upd_idx     = bus.upd_pc[IDX_BITS+1:2];
    assign lk_hist     = '0;
    assign unused_hist = ^bus.upd_hist;
`endif

    // NOTE: defaulting upd_cnt_d to the current value first keeps this block latch-free.
    always_comb begin
        upd_cnt   = table_q[upd_idx];
        upd_cnt_d = upd_cnt;
        if (bus.taken && upd_cnt != CNT_MAX) begin
            upd_cnt_d = upd_cnt + 1'b1;
        end else if (!bus.taken && upd_cnt != '0) begin
            upd_cnt_d = upd_cnt - 1'b1;
        end
    end

    // NOTE: every entry must read weakly not-taken right after reset, so the table is
    // flop-based and cleared in place rather than mapped to a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CNT_INIT;
            end
        end else if (bus.branch) begin
            table_q[upd_idx] <= upd_cnt_d;
        end
    end

    // Lookup reads table_q before this edge's update lands: read-old, no bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            prediction_q <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_hist_q  <= '0;
        end else begin
            pred_valid_q <= bus.lookup;
            if (bus.lookup) begin
                prediction_q <= table_q[lk_idx][CNT_WIDTH-1];
                pred_hist_q  <= lk_hist;
            end
        end
    end

    assign bus.prediction = prediction_q;
    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_hist  = pred_hist_q;
endmodule

// File: tb/tb_bp_counter_table.sv
// Self-checking bench for bp_counter_table: directed test-plan steps, then random traffic
// compared against an integer-arithmetic reference model of the counter table.
module tb_bp_counter_table;
    localparam int CNT_WIDTH = 2;
    localparam int IDX_BITS  = 6;
    localparam int PC_WIDTH  = 32;
    localparam int ENTRIES   = 1 << IDX_BITS;
    localparam int CNT_MAXV  = (1 << CNT_WIDTH) - 1;
    localparam int CNT_HALF  = 1 << (CNT_WIDTH - 1);

    logic clk = 1'b0;
    logic reset;

    bp_counter_table_if #(.PC_WIDTH(PC_WIDTH), .IDX_BITS(IDX_BITS)) bus ();

    bp_counter_table #(
        .CNT_WIDTH(CNT_WIDTH),
        .IDX_BITS (IDX_BITS),
        .PC_WIDTH (PC_WIDTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cnt_m [ENTRIES];
    int ghr_m;
    int exp_valid;
    int exp_pred;
    int exp_hist;
    int checks   = 0;
    int failures = 0;

    function automatic int pc_idx(input logic [PC_WIDTH-1:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model across the edge, then compare all outputs.
    task automatic cycle(input logic rst, input logic lk, input logic [PC_WIDTH-1:0] lpc,
                         input logic br, input logic [PC_WIDTH-1:0] upc, input logic tk,
                         input logic [IDX_BITS-1:0] uh);
        int li;
        int ui;
        reset         = rst;
        bus.lookup    = lk;
        bus.lookup_pc = lpc;
        bus.branch    = br;
        bus.upd_pc    = upc;
        bus.taken     = tk;
        bus.upd_hist  = uh;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) cnt_m[i] = CNT_HALF - 1;
            ghr_m     = 0;
            exp_valid = 0;
            exp_pred  = 0;
            exp_hist  = 0;
        end else begin
            exp_valid = int'(lk);
            if (lk) begin
                li = pc_idx(lpc);
`ifdef BP_COUNTER_TABLE_GHR_EN
                li = li ^ ghr_m;
                exp_hist = ghr_m;
`else
                exp_hist = 0;
`endif
                exp_pred = (cnt_m[li] >= CNT_HALF) ? 1 : 0;
            end
            if (br) begin
                ui = pc_idx(upc);
`ifdef BP_COUNTER_TABLE_GHR_EN
                ui = ui ^ int'(uh);
                ghr_m = ((ghr_m * 2) + int'(tk)) % ENTRIES;
`endif
                if (tk) cnt_m[ui] = (cnt_m[ui] < CNT_MAXV) ? cnt_m[ui] + 1 : CNT_MAXV;
                else    cnt_m[ui] = (cnt_m[ui] > 0) ? cnt_m[ui] - 1 : 0;
            end
        end
        #1;
        check("pred_valid", 32'(bus.pred_valid), 32'(exp_valid));
        check("prediction", 32'(bus.prediction), 32'(exp_pred));
        check("pred_hist",  32'(bus.pred_hist),  32'(exp_hist));
    endtask

    task automatic look(input logic [PC_WIDTH-1:0] pc);
        cycle(1'b0, 1'b1, pc, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic upd(input logic [PC_WIDTH-1:0] pc, input logic tk);
        cycle(1'b0, 1'b0, '0, 1'b1, pc, tk, '0);
    endtask

    task automatic look_upd(input logic [PC_WIDTH-1:0] pc, input logic tk);
        cycle(1'b0, 1'b1, pc, 1'b1, pc, tk, '0);
    endtask

    initial begin
        for (int i = 0; i < ENTRIES; i++) cnt_m[i] = 0;
        ghr_m = 0; exp_valid = 0; exp_pred = 0; exp_hist = 0;

        // Reset held two cycles with a lookup and update that must be dropped.
        cycle(1'b1, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, '0);
        check("reset_valid0", 32'(bus.pred_valid), 32'd0);
        cycle(1'b1, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, '0);
        check("reset_valid1", 32'(bus.pred_valid), 32'd0);
        check("reset_pred",   32'(bus.prediction), 32'd0);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        check("post_reset_valid", 32'(bus.pred_valid), 32'd0);
        look(32'h0);
        check("reset_pc0",  32'(bus.prediction), 32'd0);
        look(32'hFC);
        check("reset_pcfc", 32'(bus.prediction), 32'd0);

        // Taken with branch low must not move any counter.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0, 32'h10, 1'b1, '0);
        look(32'h10);
        check("gated_by_branch", 32'(bus.prediction), 32'd0);

        // Upward saturation on 0x10; each lookup sees the value before its same-cycle update.
        look_upd(32'h10, 1'b1);
        look_upd(32'h10, 1'b1);
        check("sat_up_first", 32'(bus.prediction), 32'd1);
        look_upd(32'h10, 1'b1);
        look_upd(32'h10, 1'b1);
        look_upd(32'h10, 1'b1);
        look(32'h10);
        check("sat_up_hold", 32'(bus.prediction), 32'd1);
        look_upd(32'h10, 1'b0);
        look_upd(32'h10, 1'b0);
        check("down_from_10", 32'(bus.prediction), 32'd1);
        look(32'h10);
        check("down_to_01", 32'(bus.prediction), 32'd0);

        // Downward saturation on 0x20 and its alias 0x120.
        for (int i = 0; i < 4; i++) upd(32'h20, 1'b0);
        look(32'h20);
        check("sat_down_20",  32'(bus.prediction), 32'd0);
        look(32'h120);
        check("sat_down_120", 32'(bus.prediction), 32'd0);
        upd(32'h120, 1'b1);
        look(32'h20);
        check("down_hold_00", 32'(bus.prediction), 32'd0);
        upd(32'h120, 1'b1);
        look(32'h20);
        check("alias_10", 32'(bus.prediction), 32'd1);

        // Same-cycle lookup and update: read-old, then the new value is visible.
        look_upd(32'h30, 1'b1);
        check("conflict_old", 32'(bus.prediction), 32'd0);
        look(32'h30);
        check("conflict_new", 32'(bus.prediction), 32'd1);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        check("valid_drop", 32'(bus.pred_valid), 32'd0);
        check("pred_holds", 32'(bus.prediction), 32'd1);

`ifdef BP_COUNTER_TABLE_GHR_EN
        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        upd(32'h100, 1'b1);
        upd(32'h104, 1'b1);
        upd(32'h108, 1'b1);
        look(32'h0);
        check("ghr_hist", 32'(bus.pred_hist), 32'h07);
        cycle(1'b0, 1'b0, '0, 1'b1, 32'h40, 1'b1, 6'h07);
        look(32'h60);
        check("gshare_entry17", 32'(bus.prediction), 32'd1);
        look(32'h40);
        check("gshare_other", 32'(bus.prediction), 32'd0);
`endif

        // Random traffic with heavy index reuse, occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic [PC_WIDTH-1:0] lpc;
            logic [PC_WIDTH-1:0] upc;
            lpc = PC_WIDTH'(($urandom_range(0, 15) << 2) | (($urandom & 1) << 8) | ($urandom & 3));
            upc = PC_WIDTH'(($urandom_range(0, 15) << 2) | (($urandom & 1) << 8));
            cycle(($urandom_range(0, 99) == 0), 1'($urandom), lpc, 1'($urandom), upc,
                  1'($urandom), IDX_BITS'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bp_counter_table.md
# bp_counter_table

Parametrised branch-direction predictor and successor to the single `sat_count` 2-bit counter. It holds a table of 2^IDX_BITS saturating counters of CNT_WIDTH bits each, indexed by PC bits. It serves one registered lookup and one update per cycle. It sits between fetch, which looks up, and the execute/branch-resolve stage, which updates.

## Interface
Parameters:
- `CNT_WIDTH`, default 2: bits per saturating counter, legal range 1..4.
- `IDX_BITS`, default 6: table index width; the table has 2^IDX_BITS entries.
- `PC_WIDTH`, default 32: PC width; must be at least IDX_BITS+2.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `lookup`  in  1: lookup request this cycle.
- `lookup_pc`  in  PC_WIDTH: PC of the instruction being fetched.
- `prediction`  out  1: predicted taken (1) or not-taken (0), valid when `pred_valid`=1.
- `pred_valid`  out  1: `prediction` and `pred_hist` correspond to the lookup of the previous cycle.
- `pred_hist`  out  IDX_BITS: global history used by that lookup; 0 when `GHR_EN` is undefined.
- `branch`  in  1: update request; a resolved branch is presented.
- `upd_pc`  in  PC_WIDTH: PC of the resolved branch.
- `taken`  in  1: resolved direction.
- `upd_hist`  in  IDX_BITS: `pred_hist` value returned with the branch; ignored when `GHR_EN` is undefined.

## Operation
- Index function: `pc_idx = pc[IDX_BITS+1:2]`, word-aligned.
- Lookup index is `pc_idx(lookup_pc)`, XOR `ghr` when `GHR_EN` is defined.
- Update index is `pc_idx(upd_pc)`, XOR `upd_hist` when `GHR_EN` is defined.
- Counter value range is 0..MAX, where MAX = 2^CNT_WIDTH−1. Predict taken iff the counter MSB = 1.
- Update on `branch`=1:
  - `taken`=1 and counter < MAX: increment.
  - `taken`=0 and counter > 0: decrement.
  - Otherwise hold. The counter never wraps.
- `branch`=0: no counter changes, regardless of `taken`.
- Reset: every entry is set to weakly not-taken, 2^(CNT_WIDTH−1)−1 (01 for width 2; 0 for width 1).
- Reset values of the outputs and history register:
  - `ghr` = 0.
  - `prediction` = 0.
  - `pred_valid` = 0.
  - `pred_hist` = 0.
- `reset` has priority over `lookup` and `branch` in the same cycle. A lookup or update in a reset cycle is dropped.

## Timing
- Lookup latency is 1 cycle. `lookup` sampled at edge N gives `pred_valid`=1 and `prediction`/`pred_hist` after edge N.
- `pred_valid` drops to 0 the cycle after a cycle with `lookup`=0. When `pred_valid`=0, `prediction` holds its last value.
- Update takes effect at the edge where `branch` is sampled. A lookup of that entry in a later cycle sees the new value.
- A lookup and an update to the same index in the same cycle read the value before the update (read-old). No bypass.
- Throughput: one lookup plus one update per cycle, sustained, with no stalls.
- `ghr` update, `GHR_EN` only: on `branch`=1, `ghr <= {ghr[IDX_BITS-2:0], taken}` at the same edge. A same-cycle lookup uses the pre-shift `ghr`.

## Configuration
- Macro `BP_COUNTER_TABLE_GHR_EN`.
- Defined: gshare mode.
  - The IDX_BITS-bit global history register is present and XORed into both indices.
  - `pred_hist` carries the `ghr` value used by the lookup.
- Undefined: bimodal mode.
  - No history register.
  - Indices are pure PC bits.
  - `pred_hist` is tied to 0.
  - `upd_hist` is unused.

## Test plan
- Reset behaviour: hold `reset` for 2 cycles, release, then look up PC 0x0 and 0xFC. Required: `prediction`=0 on both. `pred_valid`=0 during reset and the cycle after.
- Updates gated by `branch`: with `branch`=0 and `taken`=1 for 4 cycles, look up PC 0x10. Required: `prediction`=0 (counter still 01).
- Saturation upward: 5 updates on PC 0x10 with `taken`=1. Required:
  - `prediction`=1 after the first update (10).
  - Counter at 11 after the second update.
  - Further updates hold it at 11 and `prediction` stays 1, with no wrap.
  - 2 updates with `taken`=0 then give 11→10→01, and `prediction` changes 1→0 after the second.
- Saturation downward and aliasing: 4 updates on PC 0x20 with `taken`=0, then look up PC 0x20 and PC 0x120 (same index when IDX_BITS=6). Required: `prediction`=0 on both, and the counter holds at 00.
- Same-cycle read/update conflict: lookup and `branch`=1/`taken`=1 on PC 0x30 in the same cycle, from 01. Required: `prediction`=0 that cycle and `prediction`=1 on a lookup the following cycle.
- `BP_COUNTER_TABLE_GHR_EN`: 3 taken updates on distinct PCs. Required: `pred_hist`=0b000111 on the next lookup. An update on PC 0x40 with `upd_hist`=0b000111 modifies entry 0x10 ^ 0x07 = 0x17 only.
